// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//  - SEG_A..SEG_G : bit positions of each segment within a {g,f,e,d,c,b,a} word
//  - hex7()       : hex nibble to active-high segment pattern
package seg_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high {g,f,e,d,c,b,a}. Lower-case glyphs are used for b and d so
  // that they are not confused with 8 and 0.
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_edge_sync.sv
// Brings the divided scan square wave into the clk_in domain and turns each
// rising edge into a single-cycle pulse. The scan wave is treated as data.
//  clk_in : system clock
//  rst    : synchronous, active-high reset
//  sig_in : asynchronous level input (divided clock)
//  pulse  : one clk_in cycle high per rising edge of sig_in
module scan_edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic pulse
);

  logic sq0, sq1, sq2;

  // sq0/sq1 form the metastability filter; sq2 holds the previous settled
  // level so only a 0->1 transition produces a pulse, however long the high.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sq0 <= 1'b0;
      sq1 <= 1'b0;
      sq2 <= 1'b0;
    end else begin
      sq0 <= sig_in;
      sq1 <= sq0;
      sq2 <= sq1;
    end
  end

  assign pulse = sq1 & ~sq2;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment display driver. Each rising edge of the divided
// scan clock advances to the next digit; a whole frame of display data is
// captured when digit 0 comes round so a frame is never torn mid-scan.
//  clk_in      : system clock (only clock)
//  rst         : synchronous, active-high reset
//  scan_clk    : divided square wave, used as a scan-rate level
//  data_in     : hex nibbles, digit k = data_in[4k+3:4k]
//  dp_in       : decimal point per digit
//  digit_en    : per-digit enable; disabled digits stay dark
//  seg_out     : shared segments {g,f,e,d,c,b,a}
//  dp_out      : decimal point of the current digit
//  an_out      : digit anodes, at most one asserted
//  frame_start : one-cycle pulse when digit 0 begins and a frame is latched
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [SEG_W-1:0]      seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYCLES);
  // XOR mask: all-ones when asserted level is low, so "off" becomes all-ones.
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic step_p0;

  logic [IDX_W-1:0]      idx_p1;
  logic [IDX_W-1:0]      idx_nxt;
  logic [BLK_W-1:0]      blank_cnt_p1;
  logic [4*N_DIGITS-1:0] shadow_data_p1;
  logic [N_DIGITS-1:0]   shadow_dp_p1;
  logic [N_DIGITS-1:0]   shadow_en_p1;
  logic                  frame_start_p1;

  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  en_sel;
  logic [N_DIGITS-1:0]   an_sel;
  logic                  lit;

  logic [SEG_W-1:0]      seg_p2;
  logic                  dp_p2;
  logic [N_DIGITS-1:0]   an_p2;

  // ---- stage p0: scan edge detect --------------------------------------
  scan_edge_sync u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (scan_clk),
    .pulse  (step_p0)
  );

  assign idx_nxt = (idx_p1 == IDX_LAST) ? '0 : idx_p1 + IDX_W'(1);

  // ---- stage p1: digit index, blanking, frame shadow -------------------
  // Reset parks idx on the last digit so the first step wraps to 0 and
  // latches a fresh frame. A step during blanking restarts the dead time.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      idx_p1         <= IDX_LAST;
      blank_cnt_p1   <= '0;
      shadow_data_p1 <= '0;
      shadow_dp_p1   <= '0;
      shadow_en_p1   <= '0;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= 1'b0;
      if (step_p0) begin
        idx_p1       <= idx_nxt;
        blank_cnt_p1 <= BLK_LOAD;
        if (idx_nxt == '0) begin
          shadow_data_p1 <= data_in;
          shadow_dp_p1   <= dp_in;
          shadow_en_p1   <= digit_en;
          frame_start_p1 <= 1'b1;
        end
      end else if (blank_cnt_p1 != '0) begin
        blank_cnt_p1 <= blank_cnt_p1 - BLK_W'(1);
      end
    end
  end

  always_comb begin
    nib_sel = '0;
    dp_sel  = 1'b0;
    en_sel  = 1'b0;
    an_sel  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_p1 == IDX_W'(k)) begin
        nib_sel   = shadow_data_p1[4*k +: 4];
        dp_sel    = shadow_dp_p1[k];
        en_sel    = shadow_en_p1[k];
        an_sel[k] = 1'b1;
      end
    end
  end

  assign lit = (blank_cnt_p1 == '0) && en_sel;

  // ---- stage p2: registered, polarity-corrected outputs ----------------
  always_ff @(posedge clk_in) begin
    if (rst || !lit) begin
      an_p2  <= {N_DIGITS{POL}};
      seg_p2 <= {SEG_W{POL}};
      dp_p2  <= POL;
    end else begin
      an_p2  <= an_sel ^ {N_DIGITS{POL}};
      seg_p2 <= hex7(nib_sel) ^ {SEG_W{POL}};
      dp_p2  <= dp_sel ^ POL;
    end
  end

  assign an_out      = an_p2;
  assign seg_out     = seg_p2;
  assign dp_out      = dp_p2;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        scan_clk;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;

  logic [6:0]  seg_out,     seg_out_ah;
  logic        dp_out,      dp_out_ah;
  logic [3:0]  an_out,      an_out_ah;
  logic        frame_start, frame_start_ah;

  always #5 clk_in = ~clk_in;

  seg_scan_mux #(.N_DIGITS(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .scan_clk    (scan_clk),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .an_out      (an_out),
    .frame_start (frame_start)
  );

  seg_scan_mux #(.N_DIGITS(4), .BLANK_CYCLES(2), .ACTIVE_LOW(0)) dut_ah (
    .clk_in      (clk_in),
    .rst         (rst),
    .scan_clk    (scan_clk),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .seg_out     (seg_out_ah),
    .dp_out      (dp_out_ah),
    .an_out      (an_out_ah),
    .frame_start (frame_start_ah)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         off_len;   // dark cycles just before this digit lights; -1 = any
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   fs_cnt      = 0;

  localparam logic [11:0] OFF_T = {4'hF, 7'h7F, 1'b1};

  task automatic expect_lit(input logic [3:0] an, input logic [6:0] seg,
                            input logic dp, input int off_len);
    exp_t e;
    e.an = an; e.seg = seg; e.dp = dp; e.off_len = off_len;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic scan_step();
    scan_clk = 1'b1;
    cycles(10);
    scan_clk = 1'b0;
    cycles(10);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every time the display lights a new digit, pop and compare.
  initial begin
    logic [11:0] prev;
    logic [11:0] cur;
    int          off_run;
    logic        fs_prev;
    exp_t        e;
    prev    = OFF_T;
    off_run = 0;
    fs_prev = 1'b0;
    forever begin
      @(negedge clk_in);
      cur = {an_out, seg_out, dp_out};
      vectors++;
      if ($countones(~an_out) > 1) begin
        miscompares++;
        $display("FAIL onehot: an_out=%h, required at most one asserted", an_out);
      end
      if (frame_start === 1'b1) begin
        vectors++;
        if (fs_prev) begin
          miscompares++;
          $display("FAIL fs_width: frame_start high 2 cycles, required 1");
        end
        fs_cnt++;
      end
      fs_prev = (frame_start === 1'b1);
      if (cur !== prev && cur !== OFF_T) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_digit: got an=%h seg=%h dp=%b, required none", an_out, seg_out, dp_out);
        end else begin
          e = exp_q.pop_front();
          if (cur !== {e.an, e.seg, e.dp} || (e.off_len >= 0 && off_run != e.off_len)) begin
            miscompares++;
            $display("FAIL digit: got an=%h seg=%h dp=%b dark=%0d, required an=%h seg=%h dp=%b dark=%0d",
                     an_out, seg_out, dp_out, off_run, e.an, e.seg, e.dp, e.off_len);
          end
        end
      end
      if (cur === OFF_T) off_run++;
      else               off_run = 0;
      prev = cur;
    end
  end

  initial begin
    rst      = 1'b1;
    scan_clk = 1'b0;
    data_in  = 16'h1234;
    dp_in    = 4'b0010;
    digit_en = 4'hF;

    // Reset state
    cycles(1);
    for (int c = 2; c <= 3; c++) begin
      cycles(1);
      check("rst_an",  an_out,      4'hF);
      check("rst_seg", seg_out,     7'h7F);
      check("rst_dp",  dp_out,      1'b1);
      check("rst_fs",  frame_start, 1'b0);
    end
    rst = 1'b0;
    cycles(3);

    // Frame 1: 1234, dp on digit 1
    expect_lit(4'hE, 7'h19, 1'b1, -1);
    scan_clk = 1'b1;
    cycles(10);
    check("fs_first", fs_cnt, 1);
    check("ah_an",  an_out_ah,  4'h1);
    check("ah_seg", seg_out_ah, 7'h66);
    check("ah_dp",  dp_out_ah,  1'b0);
    scan_clk = 1'b0;
    cycles(10);
    expect_lit(4'hD, 7'h30, 1'b0, 2); scan_step();
    data_in = 16'hABCD;                       // changed while digit 1 shows
    expect_lit(4'hB, 7'h24, 1'b1, 2); scan_step();
    expect_lit(4'h7, 7'h79, 1'b1, 2); scan_step();
    check("fs_mid_frame", fs_cnt, 1);

    // Frame 2: ABCD latched at wrap
    expect_lit(4'hE, 7'h21, 1'b1, 2); scan_step();
    check("fs_wrap", fs_cnt, 2);
    digit_en = 4'b0101;                       // ignored until next frame
    expect_lit(4'hD, 7'h46, 1'b0, 2); scan_step();
    expect_lit(4'hB, 7'h03, 1'b1, 2); scan_step();
    expect_lit(4'h7, 7'h08, 1'b1, 2); scan_step();

    // Frame 3: digits 1 and 3 disabled
    expect_lit(4'hE, 7'h21, 1'b1, 2); scan_step();
    check("fs_frame3", fs_cnt, 3);
    scan_step();
    expect_lit(4'hB, 7'h03, 1'b1, 22); scan_step();
    scan_step();

    // Frame 4, reset while digit 2 is lit
    expect_lit(4'hE, 7'h21, 1'b1, 22); scan_step();
    check("fs_frame4", fs_cnt, 4);
    scan_step();
    expect_lit(4'hB, 7'h03, 1'b1, 22);
    digit_en = 4'hF;
    dp_in    = 4'b0000;
    scan_clk = 1'b1;
    cycles(10);
    check("pre_rst_an", an_out, 4'hB);
    scan_clk = 1'b0;
    rst      = 1'b1;
    cycles(1);
    check("midrst_an",  an_out,      4'hF);
    check("midrst_seg", seg_out,     7'h7F);
    check("midrst_dp",  dp_out,      1'b1);
    check("midrst_fs",  frame_start, 1'b0);
    check("q_drained",  exp_q.size(), 0);
    rst = 1'b0;
    cycles(2);

    // scan_clk held high: exactly one step, wraps to digit 0
    expect_lit(4'hE, 7'h21, 1'b1, -1);
    scan_clk = 1'b1;
    cycles(100);
    check("fs_after_rst", fs_cnt, 5);
    check("held_an",  an_out,  4'hE);
    check("held_seg", seg_out, 7'h21);
    check("q_final",  exp_q.size(), 0);
    scan_clk = 1'b0;
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
